// File: rtl/lbdr_ctrl.sv
// -----------------------------------------------------------------------------
// lbdr_ctrl : parametrised LBDR routing controller.
//
// Sits between an input buffer and the switch allocator. For every HEADER flit
// it computes the output port vector {L,S,W,E,N} from the registered local
// address, routing bits (Rxy) and connectivity bits (Cx). It then holds that
// vector for the whole packet through a REQ/ACTIVE request/grant handshake.
// Routing configuration can be reloaded while the controller is idle.
//
// Optional feature macro: LBDR_DEROUTE_EN
//   defined   : a zero minimal vector with L=0 falls back to the deroute code
//               of the first blocked minimal candidate (priority N,E,W,S).
//   undefined : cfg_dr and DR_RST are unused; any zero vector flags route_err.
//
// Flit type encoding: HEADER = 3'b001, PAYLOAD = 3'b010, TAIL = 3'b100.
// -----------------------------------------------------------------------------
module lbdr_ctrl #(
   parameter int             X_W       = 2,
   parameter int             Y_W       = 2,
   parameter logic [7:0]     RXY_RST   = 8'h3C,
   parameter logic [3:0]     CX_RST    = 4'hF,
   parameter logic [X_W-1:0] CUR_X_RST = 2'd1,
   parameter logic [Y_W-1:0] CUR_Y_RST = 2'd1,
   parameter logic [7:0]     DR_RST    = 8'h00
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flit_valid,
   input  logic [2:0]     flit_id,
   input  logic [X_W-1:0] dst_x,
   input  logic [Y_W-1:0] dst_y,
   input  logic           grant,
   input  logic           cfg_we,
   input  logic [7:0]     cfg_rxy,
   input  logic [3:0]     cfg_cx,
   input  logic [X_W-1:0] cfg_cur_x,
   input  logic [Y_W-1:0] cfg_cur_y,
   input  logic [7:0]     cfg_dr,
   output logic           cfg_ack,
   output logic [4:0]     port_req,
   output logic           port_valid,
   output logic           busy,
   output logic           route_err
);

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t         state_r, state_nxt_s;

   // Configuration registers
   logic [7:0]     rxy_r;
   logic [3:0]     cx_r;
   logic [X_W-1:0] cur_x_r;
   logic [Y_W-1:0] cur_y_r;

   // Registered outputs and their next values
   logic [4:0]     port_req_r, port_req_nxt_s;
   logic           port_valid_r, port_valid_nxt_s;
   logic           route_err_r, route_err_nxt_s;
   logic           cfg_ack_r;
   logic           busy_r;
   logic           cfg_apply_s;

   // Routing datapath
   logic           n1_s, s1_s, e1_s, w1_s;
   logic [3:0]     cand_s;       // minimal candidates before Cx masking, {S,W,E,N}
   logic [4:0]     min_vec_s;    // minimal vector {L,S,W,E,N}
   logic [4:0]     route_vec_s;  // vector after optional deroute
   logic           hdr_s, tail_s;

   assign cfg_ack    = cfg_ack_r;
   assign port_req   = port_req_r;
   assign port_valid = port_valid_r;
   assign busy       = busy_r;
   assign route_err  = route_err_r;

   // Minimal LBDR port equations from the registered local address
   always_comb begin
      n1_s = (dst_y < cur_y_r);
      s1_s = (cur_y_r < dst_y);
      e1_s = (cur_x_r < dst_x);
      w1_s = (dst_x < cur_x_r);
      cand_s[0] = (n1_s & ~e1_s & ~w1_s) | (n1_s & e1_s & rxy_r[0]) | (n1_s & w1_s & rxy_r[1]);
      cand_s[1] = (e1_s & ~n1_s & ~s1_s) | (e1_s & n1_s & rxy_r[2]) | (e1_s & s1_s & rxy_r[3]);
      cand_s[2] = (w1_s & ~n1_s & ~s1_s) | (w1_s & n1_s & rxy_r[4]) | (w1_s & s1_s & rxy_r[5]);
      cand_s[3] = (s1_s & ~e1_s & ~w1_s) | (s1_s & e1_s & rxy_r[6]) | (s1_s & w1_s & rxy_r[7]);
      min_vec_s = {~n1_s & ~e1_s & ~w1_s & ~s1_s, cand_s & cx_r};
   end

`ifdef LBDR_DEROUTE_EN
   logic [7:0] dr_r;
   logic [3:0] blocked_s;
   logic [1:0] dr_code_s;
   logic       dr_found_s;
   logic [4:0] dr_vec_s;

   // Deroute code register, reloaded together with the rest of the config
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dr_r <= DR_RST;
      end else if (cfg_apply_s) begin
         dr_r <= cfg_dr;
      end
   end

   // Fall back to the deroute port of the first blocked minimal candidate
   always_comb begin
      blocked_s  = cand_s & ~cx_r;
      dr_found_s = 1'b1;
      dr_code_s  = 2'd0;
      if (blocked_s[0]) begin
         dr_code_s = dr_r[1:0];
      end else if (blocked_s[1]) begin
         dr_code_s = dr_r[3:2];
      end else if (blocked_s[2]) begin
         dr_code_s = dr_r[5:4];
      end else if (blocked_s[3]) begin
         dr_code_s = dr_r[7:6];
      end else begin
         dr_found_s = 1'b0;
      end
      case (dr_code_s)
         2'd0:    dr_vec_s = 5'b00001;
         2'd1:    dr_vec_s = 5'b00010;
         2'd2:    dr_vec_s = 5'b00100;
         2'd3:    dr_vec_s = 5'b01000;
         default: dr_vec_s = 5'b00000;
      endcase
      if ((min_vec_s == 5'd0) && dr_found_s && cx_r[dr_code_s]) begin
         route_vec_s = dr_vec_s;
      end else begin
         route_vec_s = min_vec_s;
      end
   end
`else
   logic unused_s;
   assign unused_s = ^{cfg_dr, DR_RST};

   // Without deroute the minimal vector is the final routing decision
   always_comb begin
      route_vec_s = min_vec_s;
   end
`endif

   // Routing, connectivity and local address registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxy_r   <= RXY_RST;
         cx_r    <= CX_RST;
         cur_x_r <= CUR_X_RST;
         cur_y_r <= CUR_Y_RST;
      end else if (cfg_apply_s) begin
         rxy_r   <= cfg_rxy;
         cx_r    <= cfg_cx;
         cur_x_r <= cfg_cur_x;
         cur_y_r <= cfg_cur_y;
      end
   end

   // Next-state and next-output logic of the request/grant controller
   always_comb begin
      hdr_s            = flit_valid && (flit_id == FLIT_HEADER);
      tail_s           = flit_valid && (flit_id == FLIT_TAIL);
      state_nxt_s      = state_r;
      port_req_nxt_s   = port_req_r;
      port_valid_nxt_s = port_valid_r;
      route_err_nxt_s  = route_err_r;
      cfg_apply_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A header arriving together with cfg_we wins and uses the old config
            cfg_apply_s = cfg_we && !hdr_s;
            if (hdr_s) begin
               if (route_vec_s != 5'd0) begin
                  port_req_nxt_s   = route_vec_s;
                  port_valid_nxt_s = 1'b1;
                  state_nxt_s      = ST_REQ;
               end else begin
                  port_req_nxt_s   = 5'd0;
                  port_valid_nxt_s = 1'b0;
                  route_err_nxt_s  = 1'b1;
               end
            end else if (flit_valid) begin
               route_err_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (grant) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_ACTIVE: begin
            if (tail_s) begin
               port_req_nxt_s   = 5'd0;
               port_valid_nxt_s = 1'b0;
               state_nxt_s      = ST_IDLE;
            end else if (hdr_s) begin
               // Header without a preceding tail: flag it and route the new packet
               route_err_nxt_s = 1'b1;
               if (route_vec_s != 5'd0) begin
                  port_req_nxt_s   = route_vec_s;
                  port_valid_nxt_s = 1'b1;
                  state_nxt_s      = ST_REQ;
               end else begin
                  port_req_nxt_s   = 5'd0;
                  port_valid_nxt_s = 1'b0;
                  state_nxt_s      = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: begin
            port_req_nxt_s   = 5'd0;
            port_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         port_req_r   <= 5'd0;
         port_valid_r <= 1'b0;
         route_err_r  <= 1'b0;
         cfg_ack_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         port_req_r   <= port_req_nxt_s;
         port_valid_r <= port_valid_nxt_s;
         route_err_r  <= route_err_nxt_s;
         cfg_ack_r    <= cfg_apply_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_lbdr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lbdr_ctrl : self-checking bench for lbdr_ctrl.
// Directed steps followed by randomized packets checked against a
// coordinate-difference routing model. Honours LBDR_DEROUTE_EN.
// -----------------------------------------------------------------------------
module tb_lbdr_ctrl;

   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] PAY = 3'b010;
   localparam logic [2:0] TAL = 3'b100;

   logic       clk = 1'b0;
   logic       rst;
   logic       flit_valid;
   logic [2:0] flit_id;
   logic [1:0] dst_x, dst_y;
   logic       grant;
   logic       cfg_we;
   logic [7:0] cfg_rxy;
   logic [3:0] cfg_cx;
   logic [1:0] cfg_cur_x, cfg_cur_y;
   logic [7:0] cfg_dr;
   logic       cfg_ack;
   logic [4:0] port_req;
   logic       port_valid;
   logic       busy;
   logic       route_err;

   int checks   = 0;
   int failures = 0;

   // Model of the configuration currently held by the DUT
   logic [7:0] m_rxy;
   logic [3:0] m_cx;
   logic [1:0] m_cur_x, m_cur_y;
   logic [7:0] m_dr;
   logic       m_err;

   always #5 clk = ~clk;

   lbdr_ctrl dut (
      .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_id(flit_id),
      .dst_x(dst_x), .dst_y(dst_y), .grant(grant), .cfg_we(cfg_we),
      .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_cur_x(cfg_cur_x),
      .cfg_cur_y(cfg_cur_y), .cfg_dr(cfg_dr), .cfg_ack(cfg_ack),
      .port_req(port_req), .port_valid(port_valid), .busy(busy),
      .route_err(route_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] id, input int x, input int y);
      flit_valid = 1'b1;
      flit_id    = id;
      dst_x      = 2'(x);
      dst_y      = 2'(y);
   endtask

   task automatic model_reset();
      m_rxy   = 8'h3C;
      m_cx    = 4'hF;
      m_cur_x = 2'd1;
      m_cur_y = 2'd1;
      m_dr    = 8'h00;
      m_err   = 1'b0;
   endtask

   // Port index: 0=N 1=E 2=W 3=S 4=L. A port is productive when it reduces the
   // distance; with a diagonal destination the routing bit chooses it.
   function automatic logic [4:0] model_route(input int cx, input int cy, input int tx, input int ty);
      int ddx = tx - cx;
      int ddy = ty - cy;
      bit ok[4];
      logic [4:0] v = 5'd0;
      if (ddx == 0 && ddy == 0) return 5'b10000;
      ok[0] = (ddy < 0) && ((ddx == 0) || m_rxy[0 + ((ddx < 0) ? 1 : 0)]);
      ok[3] = (ddy > 0) && ((ddx == 0) || m_rxy[6 + ((ddx < 0) ? 1 : 0)]);
      ok[1] = (ddx > 0) && ((ddy == 0) || m_rxy[2 + ((ddy > 0) ? 1 : 0)]);
      ok[2] = (ddx < 0) && ((ddy == 0) || m_rxy[4 + ((ddy > 0) ? 1 : 0)]);
      for (int p = 0; p < 4; p++) begin
         if (ok[p] && m_cx[p]) v[p] = 1'b1;
      end
`ifdef LBDR_DEROUTE_EN
      if (v == 5'd0) begin
         for (int p = 0; p < 4; p++) begin
            if (ok[p] && !m_cx[p]) begin
               int code = int'(m_dr[2*p +: 2]);
               if (m_cx[code]) v[code] = 1'b1;
               break;
            end
         end
      end
`endif
      return v;
   endfunction

   initial begin
      logic [4:0] exp_v, exp2_v;
      int tx, ty;

      rst = 1'b0; flit_valid = 1'b0; flit_id = PAY; dst_x = 2'd0; dst_y = 2'd0;
      grant = 1'b0; cfg_we = 1'b0; cfg_rxy = 8'h00; cfg_cx = 4'h0;
      cfg_cur_x = 2'd0; cfg_cur_y = 2'd0; cfg_dr = 8'h00;
      model_reset();

      // Reset state
      tick(); tick();
      chk("rst_port_req", port_req, 5'd0);
      chk("rst_port_valid", port_valid, 1'b0);
      chk("rst_cfg_ack", cfg_ack, 1'b0);
      chk("rst_route_err", route_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      tick();

      // HEADER dst=(1,0) -> N, held in REQ until grant
      send(HDR, 1, 0); tick(); flit_valid = 1'b0;
      chk("n_port_req", port_req, 5'b00001);
      chk("n_port_valid", port_valid, 1'b1);
      chk("n_busy", busy, 1'b1);
      tick();
      chk("n_req_hold", port_req, 5'b00001);
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;
      chk("n_tail_req", port_req, 5'd0);
      chk("n_tail_busy", busy, 1'b0);

      // HEADER dst=(2,0) -> E via Ren, held through PAYLOAD, cleared after TAIL
      send(HDR, 2, 0); tick(); flit_valid = 1'b0;
      chk("e_port_req", port_req, 5'b00010);
      grant = 1'b1; tick(); grant = 1'b0;
      send(PAY, 0, 3); tick();
      chk("e_pay_req", port_req, 5'b00010);
      chk("e_pay_valid", port_valid, 1'b1);
      send(TAL, 3, 3); tick(); flit_valid = 1'b0;
      chk("e_tail_req", port_req, 5'd0);
      chk("e_tail_valid", port_valid, 1'b0);
      chk("e_tail_busy", busy, 1'b0);

      // HEADER dst=(0,2) -> W via Rws; HEADER dst=(1,1) -> L
      send(HDR, 0, 2); tick(); flit_valid = 1'b0;
      chk("w_port_req", port_req, 5'b00100);
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick();
      send(HDR, 1, 1); tick(); flit_valid = 1'b0;
      chk("l_port_req", port_req, 5'b10000);
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;
      chk("l_tail_req", port_req, 5'd0);
      chk("clean_err", route_err, 1'b0);

      // cfg_we during ACTIVE is ignored
      send(HDR, 2, 0); tick(); flit_valid = 1'b0;
      grant = 1'b1; tick(); grant = 1'b0;
      cfg_we = 1'b1; cfg_rxy = 8'h3C; cfg_cx = 4'b1101; cfg_cur_x = 2'd1; cfg_cur_y = 2'd1; cfg_dr = 8'h00;
      tick(); cfg_we = 1'b0;
      chk("act_cfg_noack", cfg_ack, 1'b0);
      chk("act_cfg_req", port_req, 5'b00010);
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;

      // cfg_we coincident with HEADER is ignored; header uses old config
      cfg_we = 1'b1; send(HDR, 2, 1); tick(); cfg_we = 1'b0; flit_valid = 1'b0;
      chk("hdr_cfg_req", port_req, 5'b00010);
      chk("hdr_cfg_noack", cfg_ack, 1'b0);
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;

      // cfg_we in IDLE: ack one cycle later, single-cycle pulse
      cfg_we = 1'b1; tick(); cfg_we = 1'b0;
      m_cx = 4'b1101;
      chk("idle_cfg_ack", cfg_ack, 1'b1);
      tick();
      chk("idle_cfg_ack_pulse", cfg_ack, 1'b0);

      // East blocked: deroute to N, or error without deroute support
      send(HDR, 2, 1); tick(); flit_valid = 1'b0;
`ifdef LBDR_DEROUTE_EN
      chk("dr_port_req", port_req, 5'b00001);
      chk("dr_route_err", route_err, 1'b0);
      chk("dr_busy", busy, 1'b1);
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;
`else
      chk("dr_port_req", port_req, 5'd0);
      chk("dr_route_err", route_err, 1'b1);
      chk("dr_busy", busy, 1'b0);
`endif

      // Reset mid-REQ clears outputs immediately and restores config
      send(HDR, 1, 0); tick(); flit_valid = 1'b0;
      chk("pre_rst_valid", port_valid, 1'b1);
      rst = 1'b0; #1;
      chk("mid_rst_req", port_req, 5'd0);
      chk("mid_rst_valid", port_valid, 1'b0);
      chk("mid_rst_err", route_err, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clk); rst = 1'b1;
      model_reset();
      tick();
      send(HDR, 2, 1); tick(); flit_valid = 1'b0;
      chk("post_rst_cfg_req", port_req, 5'b00010);
      grant = 1'b1; tick(); grant = 1'b0;

      // HEADER during ACTIVE: error and re-route
      send(HDR, 0, 0); tick(); flit_valid = 1'b0;
      chk("act_hdr_err", route_err, 1'b1);
      chk("act_hdr_req", port_req, 5'b00100);
      m_err = 1'b1;
      grant = 1'b1; tick(); grant = 1'b0;
      send(TAL, 0, 0); tick(); flit_valid = 1'b0;
      chk("act_hdr_tail", busy, 1'b0);

      // Randomized packets against the model
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            cfg_rxy = 8'($urandom); cfg_cx = 4'($urandom);
            cfg_cur_x = 2'($urandom); cfg_cur_y = 2'($urandom); cfg_dr = 8'($urandom);
            cfg_we = 1'b1; tick(); cfg_we = 1'b0;
            m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur_x = cfg_cur_x; m_cur_y = cfg_cur_y; m_dr = cfg_dr;
            chk("rnd_cfg_ack", cfg_ack, 1'b1);
         end
         if ($urandom_range(0, 7) == 0) begin
            send(PAY, 0, 0); tick(); flit_valid = 1'b0;
            m_err = 1'b1;
            chk("rnd_stray_err", route_err, m_err);
            chk("rnd_stray_busy", busy, 1'b0);
         end
         tx = $urandom_range(0, 3); ty = $urandom_range(0, 3);
         exp_v = model_route(int'(m_cur_x), int'(m_cur_y), tx, ty);
         send(HDR, tx, ty); tick(); flit_valid = 1'b0;
         if (exp_v == 5'd0) m_err = 1'b1;
         chk("rnd_hdr_req", port_req, exp_v);
         chk("rnd_hdr_valid", port_valid, exp_v != 5'd0);
         chk("rnd_hdr_err", route_err, m_err);
         if (exp_v != 5'd0) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               chk("rnd_req_hold", port_req, exp_v);
            end
            grant = 1'b1; tick(); grant = 1'b0;
            chk("rnd_act_busy", busy, 1'b1);
            repeat ($urandom_range(0, 3)) begin
               flit_valid = 1'($urandom); flit_id = PAY; tick();
               chk("rnd_act_hold", port_req, exp_v);
            end
            flit_valid = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
               tx = $urandom_range(0, 3); ty = $urandom_range(0, 3);
               exp2_v = model_route(int'(m_cur_x), int'(m_cur_y), tx, ty);
               send(HDR, tx, ty); tick(); flit_valid = 1'b0;
               m_err = 1'b1;
               chk("rnd_rehdr_err", route_err, m_err);
               chk("rnd_rehdr_req", port_req, exp2_v);
               chk("rnd_rehdr_busy", busy, exp2_v != 5'd0);
               if (exp2_v != 5'd0) begin
                  grant = 1'b1; tick(); grant = 1'b0;
               end
               exp_v = exp2_v;
            end
            if (exp_v != 5'd0) begin
               send(TAL, 0, 0); tick(); flit_valid = 1'b0;
               chk("rnd_tail_req", port_req, 5'd0);
               chk("rnd_tail_valid", port_valid, 1'b0);
               chk("rnd_tail_busy", busy, 1'b0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lbdr_ctrl.md
Name: lbdr_ctrl

Overview:
Parametrised successor to the minimal LBDR routing unit, sitting between an input buffer and the switch allocator.
- Mesh coordinate widths are parameters. Routing and connectivity bits and the local address are reloadable at run time.
- Computes the output port for each HEADER flit and holds it for the whole packet through a request/grant state machine.
- Flags protocol and unreachable-destination errors.
- Deroute support is optional (compile-time feature).

Parameters:
X_W, 2, width of X coordinate
Y_W, 2, width of Y coordinate
RXY_RST, 8'h3C, reset routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
CX_RST, 4'hF, reset connectivity bits {Cs,Cw,Ce,Cn}
CUR_X_RST, 1, reset local X
CUR_Y_RST, 1, reset local Y
DR_RST, 8'h00, reset deroute codes (2 bits per port, order N,E,W,S from LSB)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
flit_valid  in  1  input buffer has a flit at head
flit_id  in  3  `HEADER / `PAYLOAD / `TAIL encoding from parameters.sv
dst_x  in  X_W  destination X (sampled on HEADER only)
dst_y  in  Y_W  destination Y
grant  in  1  allocator grant for the current request
cfg_we  in  1  configuration write strobe
cfg_rxy  in  8  new routing bits
cfg_cx  in  4  new connectivity bits
cfg_cur_x  in  X_W  new local X
cfg_cur_y  in  Y_W  new local Y
cfg_dr  in  8  new deroute codes (ignored unless LBDR_DEROUTE_EN)
cfg_ack  out  1  one-cycle pulse: configuration applied
port_req  out  5  {L,S,W,E,N} port vector, up to 2 bits set
port_valid  out  1  port_req is a live request
busy  out  1  packet in flight (state != IDLE)
route_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (rst=0, async): state=IDLE; port_req=0, port_valid=0, cfg_ack=0, route_err=0. Config registers take their *_RST values.
- Comparators, using the registered local address:
  - N1 = dst_y<cur_y; S1 = cur_y<dst_y
  - E1 = cur_x<dst_x; W1 = dst_x<cur_x
  - Unsigned, full X_W/Y_W width; no wrap-around.
- Port equations:
  - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw) & Cn
  - E = (E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res) & Ce
  - W = (W1&~N1&~S1 | W1&N1&Rwn | W1&S1&Rws) & Cw
  - S = (S1&~E1&~W1 | S1&E1&Rse | S1&W1&Rsw) & Cs
  - L = ~N1&~E1&~W1&~S1
- States:
  - IDLE: flit_valid & HEADER → compute vector, register into port_req, set port_valid, go to REQ (1-cycle latency).
    - Vector all-zero → route_err=1, port_req=0, stay IDLE (header left for upper layer).
    - flit_valid & non-HEADER → route_err=1, stay IDLE.
  - REQ: hold port_req/port_valid stable until grant=1, then go to ACTIVE.
  - ACTIVE: port_req held, port_valid=1.
    - flit_valid & TAIL → next cycle port_req=0, port_valid=0, go to IDLE.
    - flit_valid & HEADER → route_err=1, re-route as from IDLE (go to REQ).
    - PAYLOAD and !flit_valid cycles → no change.
- Configuration:
  - cfg_we applies only in IDLE, when no HEADER arrives in the same cycle: all cfg_* registered, cfg_ack pulses next cycle.
  - cfg_we in REQ/ACTIVE, or coincident with a HEADER, is ignored (no ack). The HEADER routes with the old config.
- Single-flit packet (HEADER only, no TAIL): stays ACTIVE until a TAIL or a new HEADER arrives.

Optional Feature:
LBDR_DEROUTE_EN.
- Defined: if the minimal vector is zero and L=0, use the 2-bit deroute code of the first blocked minimal candidate (priority N,E,W,S).
  - Code 0=N, 1=E, 2=W, 3=S.
  - If the deroute port's C bit is 1: route to that single port, no error.
  - Otherwise: route_err as above.
- Undefined: cfg_dr and the DR registers are absent or unused; any zero vector gives route_err.

Test Plan:
Default config (cur=(1,1), Rxy=0x3C, Cx=F), HEADER dst=(1,0) → next cycle port_req=5'b00001, port_valid=1, state REQ.
Default config, HEADER dst=(2,0), grant, PAYLOAD, TAIL → port_req=5'b00010 held through ACTIVE; cleared the cycle after TAIL; busy drops.
Default config, HEADER dst=(0,2) → port_req=5'b00100 (W via Rws=1); HEADER dst=(1,1) → 5'b10000.
cfg_we with Cx=4'b1101, DR[3:2]=0, then HEADER dst=(2,1) → with LBDR_DEROUTE_EN port_req=5'b00001, route_err=0; without it port_req=0, route_err=1.
cfg_we during ACTIVE → no cfg_ack, routing unchanged; cfg_we in IDLE → cfg_ack pulse 1 cycle later.
rst asserted mid-REQ → port_req, port_valid and route_err go to 0 immediately; state IDLE; config back to *_RST.
